// File: rtl/maze_pkg.sv
// Shared maze geometry, tile encoding and arbiter state type for the maze RAM port.
// Tile word bit0 marks a wall; out-of-map lookups are reported as a bare wall.
package maze_pkg;

  localparam int MAZE_W        = 40;
  localparam int MAZE_H        = 30;
  localparam int MAP_DEPTH     = MAZE_W * MAZE_H;
  localparam int ADDR_W        = 11;
  localparam int DATA_W        = 5;
  localparam int TILE_WALL_BIT = 0;

  typedef logic [DATA_W-1:0] tile_t;

  localparam tile_t TILE_OOR = tile_t'(1 << TILE_WALL_BIT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR
  } arb_state_e;

endpackage

// File: rtl/maze_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins, zero latency.
// No flow control of its own; the caller masks requesters that must not win.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               vld
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    j   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!vld && req[j]) begin
        vld    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/maze_port_arbiter.sv
// Shares one single-port maze RAM between NUM_REQ readers and one writer; grant at T+1, read data at T+2.
// Level requests held until granted; a reader is masked while its own grant is showing, writes win up to WR_BURST.
module maze_port_arbiter
  import maze_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = maze_pkg::ADDR_W,
  parameter int DATA_W    = maze_pkg::DATA_W,
  parameter int MAP_DEPTH = maze_pkg::MAP_DEPTH,
  parameter int WR_BURST  = 2
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [NUM_REQ-1:0]        rd_req,
  input  logic [NUM_REQ*ADDR_W-1:0] rd_addr,
  output logic [NUM_REQ-1:0]        rd_gnt,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  input  logic                      wr_req,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  output logic                      wr_gnt,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_we,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(WR_BURST + 1);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  rd_gnt_q, rd_gnt_d;
  logic [NUM_REQ-1:0]  rd_valid_q, rd_valid_d;
  logic                gnt_oor_q, gnt_oor_d;
  logic                rsp_oor_q, rsp_oor_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    burst_q, burst_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic [NUM_REQ-1:0]  rd_elig;
  logic [NUM_REQ-1:0]  rr_gnt;
  logic [IDX_W-1:0]    rr_idx;
  logic                rr_vld;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_oor;
  logic                wr_oor;
  logic                rd_pend;
  logic                force_rd;

  // A reader still shows its request in the cycle its grant is visible; drop it for that cycle.
  assign rd_elig = rd_req & ~rd_gnt_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req (rd_elig),
    .ptr (ptr_q),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .vld (rr_vld)
  );

  assign sel_addr = rd_addr[rr_idx*ADDR_W +: ADDR_W];
  assign sel_oor  = (sel_addr >= ADDR_W'(MAP_DEPTH));
  assign wr_oor   = (wr_addr >= ADDR_W'(MAP_DEPTH));
  assign rd_pend  = |rd_req;
  assign force_rd = rr_vld && (burst_q == CNT_W'(WR_BURST));

  always_comb begin
    state_d     = ST_IDLE;
    rd_gnt_d    = '0;
    gnt_oor_d   = 1'b0;
    ptr_d       = ptr_q;
    burst_d     = rd_pend ? burst_q : '0;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    rd_valid_d  = rd_gnt_q;
    rsp_oor_d   = gnt_oor_q;

    if (wr_req && !force_rd) begin
      state_d = ST_WR;
      if (rd_pend && (burst_q != CNT_W'(WR_BURST))) begin
        burst_d = burst_q + CNT_W'(1);
      end
      if (!wr_oor) begin
        mem_addr_d  = wr_addr;
        mem_we_d    = 1'b1;
        mem_wdata_d = wr_data;
      end
    end else if (rr_vld) begin
      state_d   = ST_RD;
      rd_gnt_d  = rr_gnt;
      gnt_oor_d = sel_oor;
      burst_d   = '0;
      ptr_d     = (rr_idx == IDX_W'(NUM_REQ - 1)) ? '0 : rr_idx + IDX_W'(1);
      if (!sel_oor) begin
        mem_addr_d = sel_addr;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      rd_gnt_q    <= '0;
      rd_valid_q  <= '0;
      gnt_oor_q   <= 1'b0;
      rsp_oor_q   <= 1'b0;
      ptr_q       <= '0;
      burst_q     <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_gnt_q    <= rd_gnt_d;
      rd_valid_q  <= rd_valid_d;
      gnt_oor_q   <= gnt_oor_d;
      rsp_oor_q   <= rsp_oor_d;
      ptr_q       <= ptr_d;
      burst_q     <= burst_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign rd_gnt    = rd_gnt_q;
  assign wr_gnt    = (state_q == ST_WR);
  assign rd_valid  = rd_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

  // The RAM's registered read lands together with rd_valid, so only the select is flopped here.
  assign rd_data = (|rd_valid_q) ? (rsp_oor_q ? DATA_W'(TILE_OOR) : mem_rdata) : '0;

endmodule

// File: tb/tb_maze_port_arbiter.sv
// Directed bench for maze_port_arbiter with a synchronous-read RAM model and a grant/response scoreboard.
module tb_maze_port_arbiter;
  import maze_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [3:0]  rd_req;
  logic [43:0] rd_addr;
  logic [3:0]  rd_gnt;
  logic [3:0]  rd_valid;
  logic [4:0]  rd_data;
  logic        wr_req;
  logic [10:0] wr_addr;
  logic [4:0]  wr_data;
  logic        wr_gnt;
  logic [10:0] mem_addr;
  logic        mem_we;
  logic [4:0]  mem_wdata;
  logic [4:0]  mem_rdata;

  maze_port_arbiter dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_gnt    (rd_gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_gnt    (wr_gnt),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 Clk = ~Clk;

  tile_t ram [0:2047];
  always @(posedge Clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    int idx;
    int data;
  } rsp_t;

  int   exp_gnt[$];
  rsp_t exp_rsp[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_rd(input int idx, input int data);
    rsp_t r;
    r.idx  = idx;
    r.data = data;
    exp_gnt.push_back(idx);
    exp_rsp.push_back(r);
  endtask

  task automatic exp_wr();
    exp_gnt.push_back(4);
  endtask

  function automatic int oh2idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Scoreboard monitor: grant order and response contents, sampled mid-cycle.
  logic [3:0] prev_gnt = '0;
  int         code;
  rsp_t       e;
  always @(negedge Clk) begin
    if (!Reset_n) begin
      prev_gnt = '0;
    end else begin
      if (wr_gnt || (rd_gnt != 4'b0)) begin
        chk("gnt_onehot", $countones({wr_gnt, rd_gnt}), 1);
        code = wr_gnt ? 4 : oh2idx(rd_gnt);
        if (exp_gnt.size() == 0) chk("gnt_unexpected", code, -1);
        else chk("gnt_order", code, exp_gnt.pop_front());
      end
      if (rd_valid != 4'b0) begin
        chk("valid_latency", rd_valid, prev_gnt);
        if (exp_rsp.size() == 0) begin
          chk("valid_unexpected", rd_valid, 0);
        end else begin
          e = exp_rsp.pop_front();
          chk("valid_idx", rd_valid, 1 << e.idx);
          chk("rd_data", rd_data, e.data);
        end
      end
      prev_gnt = rd_gnt;
    end
  end

  // Each requester drops its request in the cycle it sees its own grant.
  task automatic run_mix(input logic do_wr, input logic [10:0] waddr, input logic [4:0] wdata,
                         input logic exp_we, input logic [10:0] exp_maddr, input logic [3:0] mask);
    wr_addr = waddr;
    wr_data = wdata;
    wr_req  = do_wr;
    rd_req  = mask;
    for (int c = 0; c < 20 && (wr_req || rd_req != 4'b0); c++) begin
      @(posedge Clk);
      #1;
      if (wr_gnt) begin
        chk("wr_mem_we", mem_we, exp_we);
        chk("wr_mem_addr", mem_addr, exp_maddr);
        wr_req = 1'b0;
      end
      rd_req = rd_req & ~rd_gnt;
    end
    chk("mix_done", {wr_req, rd_req}, 0);
    repeat (3) @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int widx;
    int ridx;
    for (int i = 0; i < 2048; i++) ram[i] = 5'(i) ^ 5'h08;
    Reset_n = 1'b0;
    rd_req  = '0;
    rd_addr = '0;
    wr_req  = 1'b0;
    wr_addr = '0;
    wr_data = '0;

    repeat (2) @(posedge Clk);
    #1;
    chk("rst_rd_gnt", rd_gnt, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_wr_gnt", wr_gnt, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // All four requesting from pointer 0: 0,1,2,3,0.
    for (int i = 0; i < 4; i++) rd_addr[i*11 +: 11] = 11'(i);
    exp_rd(0, 5'h08); exp_rd(1, 5'h09); exp_rd(2, 5'h0A); exp_rd(3, 5'h0B); exp_rd(0, 5'h08);
    rd_req = 4'hF;
    @(posedge Clk);
    #1;
    chk("first_gnt_latency", rd_gnt, 4'b0001);
    repeat (4) @(posedge Clk);
    #1;
    rd_req = '0;
    repeat (3) @(posedge Clk);
    #1;

    // Single read of tile 41 (wall).
    rd_addr[2*11 +: 11] = 11'd41;
    exp_rd(2, 5'h01);
    run_mix(1'b0, 11'd0, 5'd0, 1'b0, 11'd0, 4'b0100);

    // Write burst guard: W,W,R0,W,W,R0,W.
    exp_wr(); exp_wr(); exp_rd(0, 5'h04); exp_wr(); exp_wr(); exp_rd(0, 5'h05); exp_wr();
    widx = 0;
    ridx = 0;
    wr_addr = 11'd200;
    wr_data = 5'h11;
    wr_req  = 1'b1;
    rd_addr[10:0] = 11'd300;
    rd_req  = 4'b0001;
    for (int c = 0; c < 30 && (wr_req || rd_req != 4'b0); c++) begin
      @(posedge Clk);
      #1;
      if (wr_gnt) begin
        widx++;
        if (widx == 5) wr_req = 1'b0;
        else begin
          wr_addr = 11'(200 + widx);
          wr_data = 5'(17 + widx);
        end
      end
      if (rd_gnt[0]) begin
        ridx++;
        if (ridx == 2) rd_req = '0;
        else rd_addr[10:0] = 11'd301;
      end
    end
    chk("burst_done", {wr_req, rd_req}, 0);
    repeat (3) @(posedge Clk);
    #1;

    // Write tile 100 then read it on the very next grant.
    rd_addr[1*11 +: 11] = 11'd100;
    exp_wr();
    exp_rd(1, 5'h00);
    run_mix(1'b1, 11'd100, 5'h00, 1'b1, 11'd100, 4'b0010);

    // Read back burst writes.
    rd_addr[2*11 +: 11] = 11'd200;
    rd_addr[3*11 +: 11] = 11'd203;
    exp_rd(2, 5'h11);
    exp_rd(3, 5'h14);
    run_mix(1'b0, 11'd0, 5'd0, 1'b0, 11'd0, 4'b1100);

    // Out-of-range reads and write.
    rd_addr[0*11 +: 11] = 11'd1200;
    rd_addr[1*11 +: 11] = 11'd2047;
    exp_rd(0, 5'h01);
    exp_rd(1, 5'h01);
    run_mix(1'b0, 11'd0, 5'd0, 1'b0, 11'd0, 4'b0011);
    chk("oor_rd_mem_addr", mem_addr, 11'd203);
    exp_wr();
    run_mix(1'b1, 11'd1500, 5'h1F, 1'b0, 11'd203, 4'b0000);
    chk("oor_wr_ram_intact", ram[1500], 5'h14);

    // Reset between grant and data.
    rd_addr[1*11 +: 11] = 11'd41;
    rd_req = 4'b0010;
    @(posedge Clk);
    #1;
    chk("pre_rst_gnt", rd_gnt, 4'b0010);
    rd_req  = '0;
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_rd_gnt", rd_gnt, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge Clk);
      #1;
      chk("no_stale_valid", rd_valid, 0);
    end
    for (int i = 0; i < 4; i++) rd_addr[i*11 +: 11] = 11'(i);
    exp_rd(0, 5'h08); exp_rd(1, 5'h09); exp_rd(2, 5'h0A); exp_rd(3, 5'h0B);
    run_mix(1'b0, 11'd0, 5'd0, 1'b0, 11'd0, 4'hF);

    repeat (3) @(posedge Clk);
    #1;
    chk("gnt_queue_empty", exp_gnt.size(), 0);
    chk("rsp_queue_empty", exp_rsp.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
